// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - schedules keyboard slot note-on/off events onto synth voices
// Scans slots two cycles each (off, then on) and allocates with re-strike/idle/release/steal priority.
module voice_allocator #(
  parameter int NUM_VOICES    = 3,
  parameter int NUM_SLOTS     = 3,
  parameter int RELEASE_TICKS = 4096,
  parameter int AGE_W         = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_tick,
  input  logic [NUM_SLOTS-1:0]    slot_valid,
  input  logic [7*NUM_SLOTS-1:0]  slot_note,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    steal
);

  localparam int REL_W  = $clog2(RELEASE_TICKS + 1);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {V_IDLE, V_HELD, V_REL} vstate_e;
  typedef enum logic {CHK_OFF, CHK_ON} scan_e;

  scan_e             scan_q, scan_d;
  logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
  logic              snap_valid_q [NUM_SLOTS];
  logic              snap_valid_d [NUM_SLOTS];
  logic [6:0]        snap_note_q  [NUM_SLOTS];
  logic [6:0]        snap_note_d  [NUM_SLOTS];
  vstate_e           vstate_q     [NUM_VOICES];
  vstate_e           vstate_d     [NUM_VOICES];
  logic [6:0]        vnote_q      [NUM_VOICES];
  logic [6:0]        vnote_d      [NUM_VOICES];
  logic [AGE_W-1:0]  age_q        [NUM_VOICES];
  logic [AGE_W-1:0]  age_d        [NUM_VOICES];
  logic [REL_W-1:0]  rel_q        [NUM_VOICES];
  logic [REL_W-1:0]  rel_d        [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic              steal_q, steal_d;

  logic              cur_valid, snap_v, still_held, held_has, off_evt, on_evt;
  logic [6:0]        cur_note, snap_n;
  logic              found1, found2, found3, found4;
  logic [VIDX_W-1:0] idx1, idx2, idx3, idx4, alloc_idx;
  logic [REL_W-1:0]  best_rel;
  logic [AGE_W-1:0]  best_age;

  always_comb begin
    cur_valid = 1'b0;
    cur_note  = 7'd0;
    snap_v    = 1'b0;
    snap_n    = 7'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (SLOT_W'(i) == slot_idx_q) begin
        cur_valid = slot_valid[i];
        cur_note  = slot_note[7*i +: 7];
        snap_v    = snap_valid_q[i];
        snap_n    = snap_note_q[i];
      end
    end

    // A note held on any other slot keeps its voice gated.
    still_held = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot_valid[i] && slot_note[7*i +: 7] == snap_n) still_held = 1'b1;

    held_has = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (vstate_q[v] == V_HELD && vnote_q[v] == cur_note) held_has = 1'b1;

    off_evt = (scan_q == CHK_OFF) && snap_v && (!cur_valid || cur_note != snap_n) && !still_held;
    on_evt  = (scan_q == CHK_ON) && cur_valid && (!snap_v || cur_note != snap_n) && !held_has;

    found1 = 1'b0; found2 = 1'b0; found3 = 1'b0; found4 = 1'b0;
    idx1 = '0; idx2 = '0; idx3 = '0; idx4 = '0;
    best_rel = '0;
    best_age = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!found1 && vstate_q[v] != V_HELD && vnote_q[v] == cur_note) begin
        found1 = 1'b1; idx1 = VIDX_W'(v);
      end
      if (!found2 && vstate_q[v] == V_IDLE) begin
        found2 = 1'b1; idx2 = VIDX_W'(v);
      end
      if (vstate_q[v] == V_REL && (!found3 || rel_q[v] < best_rel)) begin
        found3 = 1'b1; idx3 = VIDX_W'(v); best_rel = rel_q[v];
      end
      if (vstate_q[v] == V_HELD && (!found4 || age_q[v] > best_age)) begin
        found4 = 1'b1; idx4 = VIDX_W'(v); best_age = age_q[v];
      end
    end
    alloc_idx = found1 ? idx1 : found2 ? idx2 : found3 ? idx3 : idx4;
  end

  always_comb begin
    scan_d     = scan_q;
    slot_idx_d = slot_idx_q;
    trig_d     = '0;
    steal_d    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      snap_valid_d[i] = snap_valid_q[i];
      snap_note_d[i]  = snap_note_q[i];
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      vstate_d[v] = vstate_q[v];
      vnote_d[v]  = vnote_q[v];
      age_d[v]    = age_q[v];
      rel_d[v]    = rel_q[v];
      if (sample_tick) begin
        if (vstate_q[v] == V_HELD && !(&age_q[v])) age_d[v] = age_q[v] + 1'b1;
        if (vstate_q[v] == V_REL) begin
          if (rel_q[v] <= REL_W'(1)) begin
            vstate_d[v] = V_IDLE;
            rel_d[v]    = '0;
          end else begin
            rel_d[v] = rel_q[v] - 1'b1;
          end
        end
      end
      if (off_evt && vstate_q[v] == V_HELD && vnote_q[v] == snap_n) begin
        vstate_d[v] = V_REL;
        rel_d[v]    = REL_W'(RELEASE_TICKS);
      end
      // Allocation overrides any tick or expiry on the chosen voice.
      if (on_evt && VIDX_W'(v) == alloc_idx) begin
        vstate_d[v] = V_HELD;
        vnote_d[v]  = cur_note;
        age_d[v]    = '0;
        rel_d[v]    = '0;
        trig_d[v]   = 1'b1;
      end
    end
    if (on_evt) steal_d = !found1 && !found2 && !found3;

    if (scan_q == CHK_OFF) begin
      scan_d = CHK_ON;
    end else begin
      scan_d = CHK_OFF;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (SLOT_W'(i) == slot_idx_q) begin
          snap_valid_d[i] = cur_valid;
          snap_note_d[i]  = cur_note;
        end
      end
      slot_idx_d = (slot_idx_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q     <= CHK_OFF;
      slot_idx_q <= '0;
      trig_q     <= '0;
      steal_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        snap_valid_q[i] <= 1'b0;
        snap_note_q[i]  <= 7'd0;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        vstate_q[v] <= V_IDLE;
        vnote_q[v]  <= 7'd0;
        age_q[v]    <= '0;
        rel_q[v]    <= '0;
      end
    end else begin
      scan_q     <= scan_d;
      slot_idx_q <= slot_idx_d;
      trig_q     <= trig_d;
      steal_q    <= steal_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        snap_valid_q[i] <= snap_valid_d[i];
        snap_note_q[i]  <= snap_note_d[i];
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        vstate_q[v] <= vstate_d[v];
        vnote_q[v]  <= vnote_d[v];
        age_q[v]    <= age_d[v];
        rel_q[v]    <= rel_d[v];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note[7*v +: 7] = vnote_q[v];
      voice_gate[v]        = (vstate_q[v] == V_HELD);
      voice_active[v]      = (vstate_q[v] != V_IDLE);
    end
  end

  assign voice_trig = trig_q;
  assign steal      = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed bench for voice_allocator (3 voices, 4 slots)
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [3:0]  slot_valid = '0;
  logic [27:0] slot_note = '0;
  logic [20:0] voice_note;
  logic [2:0]  voice_gate, voice_active, voice_trig;
  logic        steal;

  int vectors = 0;
  int miscompares = 0;
  int trig_cnt [3];
  int steal_cnt;

  voice_allocator #(
    .NUM_VOICES(3), .NUM_SLOTS(4), .RELEASE_TICKS(4096), .AGE_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
    .slot_valid(slot_valid), .slot_note(slot_note),
    .voice_note(voice_note), .voice_gate(voice_gate), .voice_active(voice_active),
    .voice_trig(voice_trig), .steal(steal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int v = 0; v < 3; v++) trig_cnt[v] += int'(voice_trig[v]);
      steal_cnt += int'(steal);
    end
  endtask

  task automatic ticks(input int n);
    sample_tick = 1'b1;
    run(n);
    sample_tick = 1'b0;
  endtask

  task automatic clear_counts();
    for (int v = 0; v < 3; v++) trig_cnt[v] = 0;
    steal_cnt = 0;
  endtask

  function automatic logic [31:0] trig_word();
    return 32'(trig_cnt[2] * 256 + trig_cnt[1] * 16 + trig_cnt[0]);
  endfunction

  task automatic set_slots(input logic [3:0] v, input logic [6:0] n0, input logic [6:0] n1,
                           input logic [6:0] n2, input logic [6:0] n3);
    slot_valid = v;
    slot_note  = {n3, n2, n1, n0};
  endtask

  initial begin
    clear_counts();
    run(2);
    check("rst_note", 32'(voice_note), 32'h0);
    check("rst_flags", 32'({voice_gate, voice_active, voice_trig, steal}), 32'h0);
    reset_n = 1'b1;
    run(2);

    // 1: first note lands on voice0
    set_slots(4'b0001, 7'h3C, 7'h00, 7'h00, 7'h00);
    run(10);
    check("t1_note", 32'(voice_note), 32'h3C);
    check("t1_gate", 32'(voice_gate), 32'h1);
    check("t1_active", 32'(voice_active), 32'h1);
    check("t1_trig", trig_word(), 32'h001);

    // 2: release lasts exactly RELEASE_TICKS ticks
    set_slots(4'b0000, 7'h3C, 7'h00, 7'h00, 7'h00);
    run(10);
    check("t2_gate", 32'(voice_gate), 32'h0);
    check("t2_active", 32'(voice_active), 32'h1);
    ticks(4095);
    check("t2_active_4095", 32'(voice_active), 32'h1);
    ticks(1);
    check("t2_active_4096", 32'(voice_active), 32'h0);
    check("t2_note", 32'(voice_note), 32'h3C);

    // 3: duplicate note on two slots shares one voice
    clear_counts();
    set_slots(4'b0011, 7'h40, 7'h40, 7'h00, 7'h00);
    run(10);
    check("t3_gate", 32'(voice_gate), 32'h1);
    check("t3_note", 32'(voice_note), 32'h40);
    check("t3_trig", trig_word(), 32'h001);
    set_slots(4'b0010, 7'h40, 7'h40, 7'h00, 7'h00);
    run(10);
    check("t3_keep", 32'(voice_gate), 32'h1);
    set_slots(4'b0000, 7'h40, 7'h40, 7'h00, 7'h00);
    run(10);
    check("t3_rel_gate", 32'(voice_gate), 32'h0);
    check("t3_rel_active", 32'(voice_active), 32'h1);

    // 4: re-strike a releasing voice in preference to an idle one
    set_slots(4'b0010, 7'h40, 7'h41, 7'h00, 7'h00);
    run(10);
    check("t4_alloc_gate", 32'(voice_gate), 32'h2);
    set_slots(4'b0000, 7'h40, 7'h41, 7'h00, 7'h00);
    run(10);
    check("t4_rel_gate", 32'(voice_gate), 32'h0);
    clear_counts();
    set_slots(4'b0001, 7'h41, 7'h41, 7'h00, 7'h00);
    run(10);
    check("t4_gate", 32'(voice_gate), 32'h2);
    check("t4_active", 32'(voice_active), 32'h3);
    check("t4_note", 32'(voice_note), 32'({7'h00, 7'h41, 7'h40}));
    check("t4_trig", trig_word(), 32'h010);

    // 5: steal the oldest held voice
    reset_n = 1'b0;
    set_slots(4'b0000, 7'h00, 7'h00, 7'h00, 7'h00);
    run(2);
    reset_n = 1'b1;
    set_slots(4'b0001, 7'h30, 7'h32, 7'h34, 7'h36);
    run(10);
    ticks(10);
    set_slots(4'b0011, 7'h30, 7'h32, 7'h34, 7'h36);
    run(10);
    ticks(10);
    set_slots(4'b0111, 7'h30, 7'h32, 7'h34, 7'h36);
    run(10);
    ticks(10);
    check("t5_pre_gate", 32'(voice_gate), 32'h7);
    clear_counts();
    set_slots(4'b1111, 7'h30, 7'h32, 7'h34, 7'h36);
    run(10);
    check("t5_steal", 32'(steal_cnt), 32'h1);
    check("t5_trig", trig_word(), 32'h001);
    check("t5_note", 32'(voice_note), 32'({7'h34, 7'h32, 7'h36}));
    check("t5_gate", 32'(voice_gate), 32'h7);
    clear_counts();
    set_slots(4'b1110, 7'h30, 7'h32, 7'h34, 7'h36);
    run(10);
    check("t5_orphan_note", 32'(voice_note), 32'({7'h34, 7'h32, 7'h36}));
    check("t5_orphan_gate", 32'(voice_gate), 32'h7);
    check("t5_orphan_trig", trig_word() | 32'(steal_cnt), 32'h0);

    // smallest release count wins over lower index
    set_slots(4'b1010, 7'h30, 7'h32, 7'h34, 7'h36);
    run(10);
    ticks(5);
    set_slots(4'b1000, 7'h30, 7'h32, 7'h34, 7'h36);
    run(10);
    clear_counts();
    set_slots(4'b1100, 7'h30, 7'h32, 7'h38, 7'h36);
    run(10);
    check("t5_rel_note", 32'(voice_note), 32'({7'h38, 7'h32, 7'h36}));
    check("t5_rel_gate", 32'(voice_gate), 32'h5);
    check("t5_rel_trig", trig_word(), 32'h100);
    check("t5_rel_steal", 32'(steal_cnt), 32'h0);

    // 6: asynchronous reset mid-sweep, then reallocation
    set_slots(4'b0111, 7'h30, 7'h32, 7'h34, 7'h36);
    run(3);
    reset_n = 1'b0;
    #2;
    check("t6_rst_note", 32'(voice_note), 32'h0);
    check("t6_rst_flags", 32'({voice_gate, voice_active, voice_trig, steal}), 32'h0);
    run(2);
    reset_n = 1'b1;
    clear_counts();
    run(10);
    check("t6_note", 32'(voice_note), 32'({7'h34, 7'h32, 7'h30}));
    check("t6_gate", 32'(voice_gate), 32'h7);
    check("t6_active", 32'(voice_active), 32'h7);
    check("t6_trig", trig_word(), 32'h111);
    check("t6_steal", 32'(steal_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Assigns held keyboard notes to the synthesizer's `sound_gen` voices. It sits between the keycode-to-note converters and the voice generators. It watches `NUM_SLOTS` note slots for note-on and note-off events and schedules each event onto one of `NUM_VOICES` voices. For each voice it drives the note, gate and retrigger, tracks per-voice release countdowns, and steals the oldest voice when all voices are busy.

## Interface
Parameters:
- `NUM_VOICES`, default 3: number of voice generators driven; range 1..8.
- `NUM_SLOTS`, default 3: number of keyboard note slots scanned; range 1..8.
- `RELEASE_TICKS`, default 4096: sample ticks a voice stays active after gate falls.
- `AGE_W`, default 16: width of the per-voice age counter, which saturates.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `reset_n`, in, 1: asynchronous active-low reset.
- `sample_tick`, in, 1: one-cycle pulse per audio frame, already synchronous to `clk`.
- `slot_valid`, in, `NUM_SLOTS`: bit s means slot s holds a pressed key.
- `slot_note`, in, `7*NUM_SLOTS`: MIDI note of slot s in bits [7s+6:7s].
- `voice_note`, out, `7*NUM_VOICES`: MIDI note assigned to voice v.
- `voice_gate`, out, `NUM_VOICES`: key held on voice v.
- `voice_active`, out, `NUM_VOICES`: voice v is gated or releasing.
- `voice_trig`, out, `NUM_VOICES`: one-cycle pulse when voice v receives a new note; used for phase/envelope reset.
- `steal`, out, 1: one-cycle pulse when a gated voice was reassigned.

## Operation
Per-voice state is one of IDLE, HELD or RELEASE.
- IDLE: gate=0, active=0.
- HELD: gate=1, active=1.
- RELEASE: gate=0, active=1, `rel_cnt` counting down.

Per-slot state is a registered snapshot `snap_valid[s]` and `snap_note[s]`.

Scanner FSM, with slot index s and states CHK_OFF and CHK_ON:
- CHK_OFF(s), note-off detection:
  - Condition: `snap_valid[s]` and (`!slot_valid[s]` or `slot_note[s] != snap_note[s]`).
  - Additionally, no currently valid slot may hold `snap_note[s]`.
  - Action: every HELD voice whose note equals `snap_note[s]` goes to RELEASE with `rel_cnt` = `RELEASE_TICKS`.
  - Next state: CHK_ON(s).
- CHK_ON(s), note-on detection:
  - Condition: `slot_valid[s]` and (`!snap_valid[s]` or the note changed).
  - Additionally, no HELD voice may already hold the note.
  - Action: allocate a voice to the note.
  - In all cases: the snapshot takes the current slot contents, s becomes (s+1) mod `NUM_SLOTS`, and the next state is CHK_OFF.
- One full sweep takes `2*NUM_SLOTS` cycles.

Allocation priority (first match wins; ties go to the lowest voice index):
1. A non-HELD voice whose `voice_note` equals the new note (re-strike).
2. An IDLE voice.
3. A RELEASE voice with the smallest `rel_cnt`.
4. The HELD voice with the largest age. This is a steal: pulse `steal`.

On allocation the chosen voice:
- loads the new note;
- enters HELD;
- clears its age to 0;
- pulses `voice_trig[v]` for one cycle.

A stolen voice's previous note is not reallocated. Its slot produces no new event until that slot changes.

Counters:
- Age: increments on `sample_tick` for every HELD voice and saturates at 2^`AGE_W`-1.
- `rel_cnt`: decrements on `sample_tick`. When it reaches 0 the voice goes to IDLE; `voice_note` is retained.

Arithmetic is unsigned throughout. Slot note compares are 7-bit equality.

## Timing
- Reset (asynchronous, immediate) clears:
  - all outputs to 0, including `voice_note`;
  - all snapshots to invalid;
  - the scanner to CHK_OFF(0);
  - all counters.
- Latency, from a slot change to the CHK_ON of that slot:
  - `voice_gate` and `voice_note` update on the following clock edge.
  - Worst-case note-on latency is `2*NUM_SLOTS` cycles.
  - `voice_trig` asserts in the same cycle that gate/note first show the new value.
- Note-off latency: the gate falls at most `2*NUM_SLOTS` cycles after the slot change.
- Slot inputs must be stable for at least `2*NUM_SLOTS` cycles. The keycode source changes far slower than this.
- Simultaneous allocation and `sample_tick` on the same voice: the allocation wins (age = 0, state HELD). `sample_tick` does not affect that voice in that cycle.
- Simultaneous release expiry and allocation: the allocation wins.
- A slot whose note changes in one step (X to Y) produces the off for X, then the on for Y, in consecutive cycles.
- `RELEASE_TICKS` = 0 is illegal.

## Test plan
1. Reset, then set slot0 to note 0x3C, valid → within 6 cycles voice0 shows note=0x3C, gate=1, active=1, with a single `voice_trig[0]` pulse; voices 1 and 2 stay 0.
2. Clear slot0 valid → gate0 falls within 6 cycles; active0 stays 1 for exactly 4096 `sample_tick`s, then goes 0; note stays 0x3C.
3. Slots 0 and 1 both hold 0x40 → only voice0 is gated. Clear slot0 → voice0 stays HELD. Clear slot1 → voice0 enters RELEASE.
4. Release 0x3C from voice0, then press 0x3C again within its release → voice0 is reused (re-strike) and `voice_trig[0]` pulses; voice1 is untouched.
5. With `NUM_SLOTS`=4, hold 0x30, 0x32 and 0x34 at 10-tick spacing, then press 0x36 → `steal` pulses and voice0 (oldest) gets 0x36 with a trig. Releasing slot0 causes no voice change.
6. Hold 3 notes, then assert `reset_n`=0 mid-sweep → all outputs are 0 immediately. Deassert with slots unchanged → the same three notes are reallocated to voices 0, 1 and 2 within 6 cycles.
